panda_mem_stage_hs: RTL

PANDA_MEM_STAGE_HS -- requirements
Module: panda_mem_stage_hs

---
 rtl/panda_pkg.sv | 51 +++++
 rtl/panda_lsu.sv | 36 +++
 rtl/panda_mem_stage_hs.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/panda_pkg.sv
// Shared types for the panda pipeline: EX->MEM and MEM->WB payloads, LSU width and MEM FSM state.
package panda_pkg;

  typedef enum logic [1:0] {
    RD_DATA_ALU  = 2'd0,
    RD_DATA_LOAD = 2'd1,
    RD_DATA_PC4  = 2'd2
  } rd_data_sel_e;

  typedef enum logic [1:0] {
    LSU_BYTE = 2'd0,
    LSU_HALF = 2'd1,
    LSU_WORD = 2'd2
  } lsu_width_e;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_RESP = 2'd2
  } mem_state_e;

  typedef struct packed {
    logic         mem_en;
    logic         mem_we;
    lsu_width_e   width;
    logic         ld_unsigned;
    logic [31:0]  alu_res;
    logic [4:0]   rs2_addr;
    logic [31:0]  rs2_data;
    logic [4:0]   rd_addr;
    logic         rd_we;
    rd_data_sel_e rd_data_sel;
  } ex_mem_t;

  typedef struct packed {
    logic [4:0]   rd_addr;
    logic         rd_we;
    rd_data_sel_e rd_data_sel;
    logic [31:0]  alu_res;
    logic [31:0]  load_data;
  } mem_wb_t;

  function automatic logic misaligned(lsu_width_e w, logic [1:0] off);
    case (w)
      LSU_HALF: return off[0];
      LSU_WORD: return off != 2'b00;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/panda_lsu.sv
// Byte-lane steering: shifts store data/enables into lanes and extracts/extends load data.
module panda_lsu
  import panda_pkg::*;
#(
  parameter int NUM_LANES = 4
) (
  input  lsu_width_e             width_i,
  input  logic                   unsigned_i,
  input  logic [1:0]             offset_i,
  input  logic [31:0]            st_data_i,
  output logic [31:0]            wdata_o,
  output logic [NUM_LANES-1:0]   be_o,
  input  logic [31:0]            rdata_i,
  output logic [31:0]            ld_data_o
);

  logic [NUM_LANES-1:0] size_mask;
  logic [31:0]          shifted;

  always_comb begin
    case (width_i)
      LSU_BYTE: size_mask = NUM_LANES'(4'b0001);
      LSU_HALF: size_mask = NUM_LANES'(4'b0011);
      default:  size_mask = NUM_LANES'(4'b1111);
    endcase
    be_o    = size_mask << offset_i;
    wdata_o = st_data_i << {offset_i, 3'b000};
    shifted = rdata_i >> {offset_i, 3'b000};
    case (width_i)
      LSU_BYTE: ld_data_o = unsigned_i ? {24'b0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
      LSU_HALF: ld_data_o = unsigned_i ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default:  ld_data_o = shifted;
    endcase
  end

endmodule

// File: rtl/panda_mem_stage_hs.sv
// MEM stage with req/gnt/rvalid data bus handshake, misalignment and timeout/bus-error handling.
module panda_mem_stage_hs
  import panda_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter bit FWD_EN  = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  ex_mem_t     ex_mem_i,
  input  logic        ex_valid_i,
  output logic        mem_ready_o,
  output mem_wb_t     mem_wb_o,
  output logic        wb_valid_o,
  output logic        data_req_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  input  logic        data_err_i,
  output logic [31:0] data_addr_o,
  output logic [3:0]  data_we_o,
  output logic [31:0] data_wdata_o,
  input  logic [31:0] data_rdata_i,
  output logic        exc_misaligned_o,
  output logic        exc_bus_err_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  mem_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q;

  logic [31:0]  addr_q, st_data_q;
  lsu_width_e   width_q;
  logic         uns_q, st_q, rd_we_q;
  logic [4:0]   rd_q;
  rd_data_sel_e sel_q;

  mem_wb_t mem_wb_q;
  logic    wb_valid_q, exc_mis_q, exc_berr_q;

  logic        accept, mis, fwd_hit, timeout, rsp, fail, done;
  logic [31:0] lsu_wdata, lsu_ld;
  logic [3:0]  lsu_be;

  assign accept  = ex_valid_i && (state_q == MEM_IDLE);
  assign mis     = misaligned(ex_mem_i.width, ex_mem_i.alu_res[1:0]);
  assign fwd_hit = FWD_EN && wb_valid_q && mem_wb_q.rd_we && (mem_wb_q.rd_data_sel == RD_DATA_LOAD)
                   && (ex_mem_i.rs2_addr != 5'd0) && (ex_mem_i.rs2_addr == mem_wb_q.rd_addr);
  // Fires in the TIMEOUT-th cycle of a state so the counter would reach TIMEOUT at that edge.
  assign timeout = (state_q != MEM_IDLE) && (cnt_q == CW'(TIMEOUT - 1));
  assign rsp     = (state_q == MEM_RESP) && data_rvalid_i;
  assign fail    = rsp ? data_err_i : timeout;
  assign done    = rsp && !data_err_i;

  panda_lsu #(.NUM_LANES(4)) u_lsu (
    .width_i    (width_q),
    .unsigned_i (uns_q),
    .offset_i   (addr_q[1:0]),
    .st_data_i  (st_data_q),
    .wdata_o    (lsu_wdata),
    .be_o       (lsu_be),
    .rdata_i    (data_rdata_i),
    .ld_data_o  (lsu_ld)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= MEM_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q)       cnt_q <= '0;
      else if (state_q != MEM_IDLE) cnt_q <= cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MEM_IDLE: if (accept && ex_mem_i.mem_en && !mis) state_d = MEM_REQ;
      MEM_REQ:  if (fail) state_d = MEM_IDLE;
                else if (data_gnt_i) state_d = MEM_RESP;
      MEM_RESP: if (rsp || fail) state_d = MEM_IDLE;
      default:  state_d = MEM_IDLE;
    endcase
  end

  always_comb begin
    mem_ready_o      = (state_q == MEM_IDLE);
    data_req_o       = (state_q == MEM_REQ);
    data_we_o        = (state_q == MEM_REQ && st_q) ? lsu_be : 4'b0000;
    data_addr_o      = {addr_q[31:2], 2'b00};
    data_wdata_o     = lsu_wdata;
    mem_wb_o         = mem_wb_q;
    wb_valid_o       = wb_valid_q;
    exc_misaligned_o = exc_mis_q;
    exc_bus_err_o    = exc_berr_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q    <= '0;
      st_data_q <= '0;
      width_q   <= LSU_BYTE;
      uns_q     <= 1'b0;
      st_q      <= 1'b0;
      rd_q      <= '0;
      rd_we_q   <= 1'b0;
      sel_q     <= RD_DATA_ALU;
    end else if (accept && ex_mem_i.mem_en && !mis) begin
      addr_q    <= ex_mem_i.alu_res;
      st_data_q <= fwd_hit ? mem_wb_q.load_data : ex_mem_i.rs2_data;
      width_q   <= ex_mem_i.width;
      uns_q     <= ex_mem_i.ld_unsigned;
      st_q      <= ex_mem_i.mem_we;
      rd_q      <= ex_mem_i.rd_addr;
      rd_we_q   <= ex_mem_i.rd_we;
      sel_q     <= ex_mem_i.rd_data_sel;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_wb_q   <= '0;
      wb_valid_q <= 1'b0;
      exc_mis_q  <= 1'b0;
      exc_berr_q <= 1'b0;
    end else begin
      wb_valid_q <= 1'b0;
      exc_mis_q  <= 1'b0;
      exc_berr_q <= 1'b0;
      if (accept && (!ex_mem_i.mem_en || mis)) begin
        // Non-memory op, or a misaligned access retiring with no bus traffic.
        mem_wb_q.rd_addr     <= ex_mem_i.rd_addr;
        mem_wb_q.rd_we       <= ex_mem_i.rd_we && !ex_mem_i.mem_en;
        mem_wb_q.rd_data_sel <= ex_mem_i.rd_data_sel;
        mem_wb_q.alu_res     <= ex_mem_i.alu_res;
        mem_wb_q.load_data   <= '0;
        wb_valid_q           <= 1'b1;
        exc_mis_q            <= ex_mem_i.mem_en;
      end else if (fail) begin
        mem_wb_q.rd_addr     <= rd_q;
        mem_wb_q.rd_we       <= 1'b0;
        mem_wb_q.rd_data_sel <= sel_q;
        mem_wb_q.alu_res     <= addr_q;
        mem_wb_q.load_data   <= '0;
        wb_valid_q           <= 1'b1;
        exc_berr_q           <= 1'b1;
      end else if (done) begin
        mem_wb_q.rd_addr     <= rd_q;
        mem_wb_q.rd_we       <= rd_we_q && !st_q;
        mem_wb_q.rd_data_sel <= sel_q;
        mem_wb_q.alu_res     <= addr_q;
        mem_wb_q.load_data   <= lsu_ld;
        wb_valid_q           <= 1'b1;
      end
    end
  end

endmodule
